// File: rtl/lb_pkg.sv
// -----------------------------------------------------------------------------
// lb_pkg
// Shared definitions for the ping-pong line buffer: the per-bank state
// encoding and the default pixel width / line depth.
// No ports (package).
// -----------------------------------------------------------------------------
package lb_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_t;

    localparam int LB_DATA_W = 24;
    localparam int LB_DEPTH  = 800;

endpackage

// File: rtl/lb_sdp_ram.sv
// -----------------------------------------------------------------------------
// lb_sdp_ram
// Simple dual-port RAM, one write port and one registered read port on a
// single clock. Contents are never reset.
// Ports:
//   clk    in  clock for both ports
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   re     in  read enable (output register updates only when set)
//   raddr  in  read address
//   rdata  out registered read data, one cycle after re
// -----------------------------------------------------------------------------
module lb_sdp_ram
    import lb_pkg::*;
#(
    parameter int DATA_W = LB_DATA_W,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_buffer_pp.sv
// -----------------------------------------------------------------------------
// line_buffer_pp
// Two-bank (ping-pong) video line buffer. The writer fills banks in
// alternation; a reader claims the oldest complete line with rd_start and
// then reads it randomly by pixel index with one cycle of latency.
// Optional feature macro: LINE_BUFFER_PP_REPEAT_EN -- an rd_start with no
// complete line re-claims the line currently held for reading so it repeats.
// Ports:
//   clk        in  single clock
//   rst        in  asynchronous active-high reset
//   wr_en      in  write one pixel
//   wr_data    in  pixel value
//   wr_last    in  final pixel of the line (qualified by wr_en)
//   wr_ready   out a bank can accept writes
//   line_avail out at least one bank holds a complete line
//   rd_start   in  claim the oldest complete line for reading
//   rd_en      in  read strobe
//   rd_addr    in  pixel index within the claimed line
//   rd_data    out read pixel (0 when out of range or nothing claimed)
//   rd_valid   out rd_en delayed by one cycle
//   overflow   out sticky: a write was dropped
//   underrun   out sticky: rd_start issued with no complete line
// -----------------------------------------------------------------------------
module line_buffer_pp
    import lb_pkg::*;
#(
    parameter int DATA_W = LB_DATA_W,
    parameter int DEPTH  = LB_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic              line_avail,
    input  logic              rd_start,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              overflow,
    output logic              underrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bank_state_t       state   [2];
    bank_state_t       state_n [2];
    // Each bank keeps the index of its final pixel (line length - 1); this
    // still fits ADDR_W when DEPTH is a power of two.
    logic [ADDR_W-1:0] last_idx   [2];
    logic [ADDR_W-1:0] last_idx_n [2];
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
    logic              wr_sel, wr_sel_n;    // bank the writer fills
    logic              rd_ptr, rd_ptr_n;    // oldest complete bank, next to claim
    logic              rd_bank, rd_bank_n;  // bank last claimed for reading

    logic              wr_accept;
    logic              claim;
    logic              rd_hit;
    logic              vld_p1;
    logic              hit_p1;
    logic [DATA_W-1:0] ram_q;

    assign wr_ready   = (state[0] == EMPTY) || (state[0] == FILLING) ||
                        (state[1] == EMPTY) || (state[1] == FILLING);
    // line_avail comes from registered state, so a bank completing this cycle
    // is only claimable from the next cycle on.
    assign line_avail = (state[0] == FULL) || (state[1] == FULL);

    assign wr_accept = wr_en && wr_ready;
    assign claim     = rd_start && line_avail;

    // Banks are filled and claimed in strict alternation, so wr_sel always
    // names the EMPTY/FILLING bank when wr_ready is set and rd_ptr always
    // names the older FULL bank when line_avail is set.
    always_comb begin
        state_n    = state;
        last_idx_n = last_idx;
        wr_ptr_n   = wr_ptr;
        wr_sel_n   = wr_sel;
        rd_ptr_n   = rd_ptr;
        rd_bank_n  = rd_bank;

        if (wr_accept) begin
            if (wr_last || (wr_ptr == LAST_ADDR)) begin
                state_n[wr_sel]    = FULL;
                last_idx_n[wr_sel] = wr_ptr;
                wr_ptr_n           = '0;
                wr_sel_n           = ~wr_sel;
            end else begin
                state_n[wr_sel] = FILLING;
                wr_ptr_n        = wr_ptr + 1'b1;
            end
        end

        if (claim) begin
            state_n[rd_ptr] = READING;
            if (state[~rd_ptr] == READING) begin
                state_n[~rd_ptr] = EMPTY;
            end
            rd_bank_n = rd_ptr;
            rd_ptr_n  = ~rd_ptr;
        end
`ifdef LINE_BUFFER_PP_REPEAT_EN
        else if (rd_start && (state[rd_bank] == READING)) begin
            // No new line: keep the held line claimed so it is read again.
            state_n[rd_bank] = READING;
            rd_bank_n        = rd_bank;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state[0]    <= EMPTY;
            state[1]    <= EMPTY;
            last_idx[0] <= '0;
            last_idx[1] <= '0;
            wr_ptr      <= '0;
            wr_sel      <= 1'b0;
            rd_ptr      <= 1'b0;
            rd_bank     <= 1'b0;
            overflow    <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state    <= state_n;
            last_idx <= last_idx_n;
            wr_ptr   <= wr_ptr_n;
            wr_sel   <= wr_sel_n;
            rd_ptr   <= rd_ptr_n;
            rd_bank  <= rd_bank_n;
            if (wr_en && !wr_ready) begin
                overflow <= 1'b1;
            end
            if (rd_start && !line_avail) begin
                underrun <= 1'b1;
            end
        end
    end

    lb_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr ({wr_sel, wr_ptr}),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr ({rd_bank, rd_addr}),
        .rdata (ram_q)
    );

    assign rd_hit = rd_en && (state[rd_bank] == READING) &&
                    (rd_addr <= last_idx[rd_bank]);

    // ---- read stage p0 -> p1 ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            hit_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            hit_p1 <= rd_hit;
        end
    end

    assign rd_valid = vld_p1;
    assign rd_data  = hit_p1 ? ram_q : '0;

endmodule

// File: tb/tb_line_buffer_pp.sv
module tb_line_buffer_pp;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 800;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_last = 1'b0;
    logic              wr_ready;
    logic              line_avail;
    logic              rd_start = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              overflow;
    logic              underrun;

    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_d;

    always #5 clk = ~clk;

    line_buffer_pp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .wr_ready   (wr_ready),
        .line_avail (line_avail),
        .rd_start   (rd_start),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic [DATA_W-1:0] d, input logic last);
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = last;
        step();
        wr_en   = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic pulse_start();
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({rd_valid, overflow, underrun, line_avail, wr_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_flags got {vld,ovf,und,avail,rdy}=%b required 00001",
                     {rd_valid, overflow, underrun, line_avail, wr_ready});
        end
        checks++;
        if (rd_data !== '0) begin
            failures++;
            $display("FAIL reset_rd_data got %0d required 0", rd_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_line();
        for (int i = 0; i < DEPTH; i++) write_px(DATA_W'(i), 1'b0);
        checks++;
        if (line_avail !== 1'b1 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_line_status got avail=%b ready=%b required 1 1", line_avail, wr_ready);
        end
        pulse_start();
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) begin
                rd_en   = 1'b1;
                rd_addr = ADDR_W'(i);
                exp_q.push_back(DATA_W'(i));
            end else begin
                rd_en = 1'b0;
            end
            step();
            if (exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
                    failures++;
                    $display("FAIL full_line_read idx=%0d got vld=%b data=%0d required vld=1 data=%0d",
                             i, rd_valid, rd_data, exp_d);
                end
            end
        end
        step();
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_line_vld_drop got %b required 0", rd_valid);
        end
    endtask

    task automatic test_short_line();
        int addrs [4] = '{0, 9, 10, 12};
        int exps  [4] = '{1000, 1009, 0, 0};
        for (int i = 0; i < 10; i++) write_px(DATA_W'(1000 + i), i == 9);
        pulse_start();
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                rd_en   = 1'b1;
                rd_addr = ADDR_W'(addrs[i]);
                exp_q.push_back(DATA_W'(exps[i]));
            end else begin
                rd_en = 1'b0;
            end
            step();
            if (exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
                    failures++;
                    $display("FAIL short_line_read idx=%0d got vld=%b data=%0d required vld=1 data=%0d",
                             i, rd_valid, rd_data, exp_d);
                end
            end
        end
    endtask

    task automatic test_underrun();
        do_reset();
        // read with nothing claimed returns 0 but stays valid
        rd_en   = 1'b1;
        rd_addr = '0;
        exp_q.push_back('0);
        step();
        rd_en = 1'b0;
        exp_d = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
            failures++;
            $display("FAIL unclaimed_read got vld=%b data=%0d required vld=1 data=0", rd_valid, rd_data);
        end
        pulse_start();
        checks++;
        if ({underrun, line_avail, wr_ready, overflow} !== 4'b1010) begin
            failures++;
            $display("FAIL underrun_flags got {und,avail,rdy,ovf}=%b required 1010",
                     {underrun, line_avail, wr_ready, overflow});
        end
        write_px(DATA_W'(700), 1'b0);
        write_px(DATA_W'(701), 1'b1);
        checks++;
        if (line_avail !== 1'b1 || underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_after_line got avail=%b und=%b required 1 1", line_avail, underrun);
        end
        pulse_start();
        for (int i = 0; i <= 2; i++) begin
            if (i < 2) begin
                rd_en   = 1'b1;
                rd_addr = ADDR_W'(i);
                exp_q.push_back(DATA_W'(700 + i));
            end else begin
                rd_en = 1'b0;
            end
            step();
            if (exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
                    failures++;
                    $display("FAIL underrun_line_read idx=%0d got vld=%b data=%0d required vld=1 data=%0d",
                             i, rd_valid, rd_data, exp_d);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 3; i++) write_px(DATA_W'(300 + i), i == 2);
        for (int i = 0; i < 3; i++) write_px(DATA_W'(310 + i), i == 2);
        checks++;
        if (wr_ready !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_pre got rdy=%b ovf=%b required 0 0", wr_ready, overflow);
        end
        write_px(DATA_W'(399), 1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_flag got %b required 1", overflow);
        end
        for (int line = 0; line < 2; line++) begin
            pulse_start();
            for (int i = 0; i <= 4; i++) begin
                if (i < 4) begin
                    rd_en   = 1'b1;
                    rd_addr = ADDR_W'(i);
                    exp_q.push_back((i < 3) ? DATA_W'(300 + 10 * line + i) : '0);
                end else begin
                    rd_en = 1'b0;
                end
                step();
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    checks++;
                    if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
                        failures++;
                        $display("FAIL overflow_read line=%0d idx=%0d got vld=%b data=%0d required vld=1 data=%0d",
                                 line, i, rd_valid, rd_data, exp_d);
                    end
                end
            end
        end
        checks++;
        if (wr_ready !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_post got rdy=%b ovf=%b required 1 1", wr_ready, overflow);
        end
    endtask

    task automatic test_coincide();
        do_reset();
        for (int i = 0; i < 4; i++) write_px(DATA_W'(200 + i), i == 3);
        write_px(DATA_W'(210), 1'b0);
        write_px(DATA_W'(211), 1'b0);
        rd_start = 1'b1;
        write_px(DATA_W'(212), 1'b1);
        rd_start = 1'b0;
        checks++;
        if (line_avail !== 1'b1 || underrun !== 1'b0 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL coincide_status got avail=%b und=%b rdy=%b required 1 0 0",
                     line_avail, underrun, wr_ready);
        end
        for (int line = 0; line < 2; line++) begin
            if (line == 1) begin
                pulse_start();
                checks++;
                if (wr_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL released_bank_ready got %b required 1", wr_ready);
                end
                write_px(DATA_W'(220), 1'b1);
                checks++;
                if (overflow !== 1'b0 || line_avail !== 1'b1) begin
                    failures++;
                    $display("FAIL released_bank_write got ovf=%b avail=%b required 0 1", overflow, line_avail);
                end
            end
            for (int i = 0; i <= 5; i++) begin
                if (i < 5) begin
                    rd_en   = 1'b1;
                    rd_addr = ADDR_W'(i);
                    if (line == 0) exp_q.push_back((i < 4) ? DATA_W'(200 + i) : '0);
                    else           exp_q.push_back((i < 3) ? DATA_W'(210 + i) : '0);
                end else begin
                    rd_en = 1'b0;
                end
                step();
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    checks++;
                    if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
                        failures++;
                        $display("FAIL coincide_read line=%0d idx=%0d got vld=%b data=%0d required vld=1 data=%0d",
                                 line, i, rd_valid, rd_data, exp_d);
                    end
                end
            end
        end
        pulse_start();
        rd_en   = 1'b1;
        rd_addr = '0;
        exp_q.push_back(DATA_W'(220));
        step();
        rd_en = 1'b0;
        exp_d = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
            failures++;
            $display("FAIL released_bank_read got vld=%b data=%0d required vld=1 data=%0d",
                     rd_valid, rd_data, exp_d);
        end
    endtask

    task automatic test_midline_reset();
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) write_px(DATA_W'(500 + i), 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_valid, overflow, underrun, line_avail, wr_ready} !== 5'b00001 || rd_data !== '0) begin
            failures++;
            $display("FAIL midline_reset_outputs got {vld,ovf,und,avail,rdy}=%b data=%0d required 00001 0",
                     {rd_valid, overflow, underrun, line_avail, wr_ready}, rd_data);
        end
        step();
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) write_px(DATA_W'(600 + i), i == 2);
        pulse_start();
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                rd_en   = 1'b1;
                rd_addr = ADDR_W'(i);
                exp_q.push_back((i < 3) ? DATA_W'(600 + i) : '0);
            end else begin
                rd_en = 1'b0;
            end
            step();
            if (exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
                    failures++;
                    $display("FAIL midline_reset_read idx=%0d got vld=%b data=%0d required vld=1 data=%0d",
                             i, rd_valid, rd_data, exp_d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_short_line();
        test_underrun();
        test_overflow();
        test_coincide();
        test_midline_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_buffer_pp.md
LINE_BUFFER_PP -- requirements
Module: line_buffer_pp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24: pixel word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 800: maximum pixels per line, and the capacity of each bank.
REQ-003 The block SHALL have parameter ADDR_W, default $clog2(DEPTH): width of the address and line-length fields.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock for all logic and both RAM ports.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port wr_en, input, 1 bit: write strobe for one pixel.
REQ-007 The block SHALL have port wr_data, input, DATA_W bits: the pixel to write.
REQ-008 The block SHALL have port wr_last, input, 1 bit: qualified by wr_en, marks the final pixel of the line.
REQ-009 The block SHALL have port wr_ready, output, 1 bit: a bank is available to accept writes.
REQ-010 The block SHALL have port line_avail, output, 1 bit: at least one bank is FULL.
REQ-011 The block SHALL have port rd_start, input, 1 bit: pulse that claims the oldest FULL bank for reading.
REQ-012 The block SHALL have port rd_en, input, 1 bit: read strobe.
REQ-013 The block SHALL have port rd_addr, input, ADDR_W bits: pixel index within the claimed line.
REQ-014 The block SHALL have port rd_data, output, DATA_W bits: read pixel, registered.
REQ-015 The block SHALL have port rd_valid, output, 1 bit: rd_data is valid this cycle.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky flag, a write was dropped.
REQ-017 The block SHALL have port underrun, output, 1 bit: sticky flag, rd_start was issued with no FULL bank.

Function
REQ-018 Each of the two banks SHALL be in exactly one state: EMPTY, FILLING, FULL or READING.
REQ-019 The writer SHALL fill an EMPTY bank sequentially from an internal wr_ptr starting at 0; the first accepted write SHALL move that bank to FILLING.
REQ-020 When wr_en is asserted with wr_last, or when wr_ptr equals DEPTH-1, the block SHALL store the bank's line length (wr_ptr+1), move the bank to FULL and clear wr_ptr to 0.
REQ-021 wr_ready SHALL be 1 when either bank is EMPTY or FILLING; a write while wr_ready=0 SHALL be dropped and SHALL set overflow.
REQ-022 rd_start while line_avail=1 SHALL move the FULL bank to READING and SHALL move any bank previously in READING to EMPTY, in the same cycle.
REQ-023 rd_start while line_avail=0 SHALL leave all bank states unchanged and SHALL set underrun.
REQ-024 Reads SHALL have latency 1: rd_valid SHALL be rd_en delayed by one cycle, and rd_data SHALL be the READING bank's word at rd_addr.
REQ-025 If rd_addr is greater than or equal to the stored line length, or no bank is READING, rd_data SHALL be 0 while rd_valid still follows rd_en.
REQ-026 When rd_start and a bank becoming FULL occur in the same cycle, rd_start SHALL act on the previous cycle's line_avail; the newly FULL bank SHALL become claimable on the next cycle.
REQ-027 When the last write of a bank and rd_start coincide, a write to the released bank SHALL be accepted starting the next cycle.

Reset
REQ-028 While rst=1, both banks SHALL be EMPTY, wr_ptr and the line lengths SHALL be 0, and the bank-select pointers SHALL be 0.
REQ-029 While rst=1, rd_data=0, rd_valid=0, overflow=0, underrun=0, line_avail=0 and wr_ready=1; RAM contents SHALL NOT be cleared.
REQ-030 A reset asserted mid-line SHALL discard the partial line, and the first write after reset SHALL land at address 0 of bank 0.

Configuration
REQ-031 With macro LINE_BUFFER_PP_REPEAT_EN defined, rd_start with no FULL bank SHALL re-claim the last READING bank, so the previous line repeats, while still setting underrun.
REQ-032 Without LINE_BUFFER_PP_REPEAT_EN, the behaviour SHALL be as in REQ-023, and no repeat logic SHALL be synthesised.

Structure
REQ-033 Package lb_pkg SHALL hold the bank state enum (EMPTY, FILLING, FULL, READING) and the default DATA_W and DEPTH constants.
REQ-034 Storage SHALL be one sub-module, lb_sdp_ram: a simple dual-port RAM with a registered read, instantiated once and addressed {bank, addr}.

Verification
REQ-035 The bench SHALL write 800 pixels of value i, then rd_start, then read addresses 0..799; the required response is rd_data=i one cycle after each read and rd_valid set.
REQ-036 The bench SHALL write 10 pixels with wr_last on the 10th, rd_start, then read address 12; the required response is rd_data=0.
REQ-037 The bench SHALL fill two lines with no rd_start, then issue one more write; the required response is wr_ready=0, the write dropped and overflow=1.
REQ-038 The bench SHALL issue rd_start after reset; the required response is underrun=1 with no state change, and with LINE_BUFFER_PP_REPEAT_EN a repeat of the last line.
REQ-039 The bench SHALL issue rd_start in the same cycle as a wr_last that completes a bank; the required response is that the claim takes the older FULL bank and the new bank becomes claimable the following cycle.
REQ-040 The bench SHALL assert rst after 5 writes; the required response is all outputs at their reset values, and the next line starting at bank 0, address 0.
